// File: rtl/parallel_hypervisor_cpu_div_pkg.sv
// Shared types and constants for the iterative divider cell.
// The signed-operation feature is controlled by PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
// in the top module; nothing in this package depends on it.
package parallel_hypervisor_cpu_div_pkg;

    // Default operand/result width of the divider.
    localparam int DIV_WIDTH_DEFAULT = 32;

    // Step counter must hold values 0..WIDTH.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/parallel_hypervisor_cpu_div_step.sv
// One radix-2 restoring division step: shift {rem,quot} left by one, trial-subtract
// the divisor from the widened partial remainder and keep the difference if it
// does not go negative. Purely combinational.
module parallel_hypervisor_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift, trial subtract, select. The difference only needs WIDTH bits: when it
    // is kept it is smaller than the divisor.
    always_comb begin
        shifted_rem = {rem_in, quot_in[WIDTH-1]};
        fits        = shifted_rem >= {1'b0, divisor};
        diff        = shifted_rem[WIDTH-1:0] - divisor;
        rem_out     = fits ? diff : shifted_rem[WIDTH-1:0];
        quot_out    = {quot_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/parallel_hypervisor_cpu_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per enabled cycle, followed
// by a sign/divide-by-zero fix-up cycle that registers the results.
// Define PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN to honour E_div_signed; without it
// every operation is unsigned and the sign logic is not built.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for E_div_start; results held on M_div_quot/rem
// ST_BUSY | WIDTH restoring steps, one per M_en cycle
// ST_FIX  | apply signs / divide-by-zero result, pulse M_div_done
module parallel_hypervisor_cpu_div_cell
    import parallel_hypervisor_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             M_en,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem,
    output logic             M_div_busy,
    output logic             M_div_done
);

    localparam int                CNT_W     = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] res_quot_q, res_quot_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q, done_d;
    logic             busy;

    logic [WIDTH-1:0] src1_mag;
    logic [WIDTH-1:0] src2_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;
    logic             start_acc;

`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
    logic src1_neg;
    logic src2_neg;

    // Operand magnitudes for signed operations; MIN maps to itself, which the
    // unsigned datapath then treats as 2^(WIDTH-1).
    always_comb begin
        src1_neg = E_div_signed & E_src1[WIDTH-1];
        src2_neg = E_div_signed & E_src2[WIDTH-1];
        src1_mag = src1_neg ? (WIDTH'(0) - E_src1) : E_src1;
        src2_mag = src2_neg ? (WIDTH'(0) - E_src2) : E_src2;
    end
`else
    logic unused_signed;

    // Unsigned-only build: operands go straight into the datapath.
    always_comb begin
        src1_mag = E_src1;
        src2_mag = E_src2;
    end
    assign unused_signed = E_div_signed;
`endif

    assign start_acc = (state_q == ST_IDLE) && E_div_start && M_en;

    parallel_hypervisor_cpu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in   (rem_q),
        .quot_in  (quot_q),
        .divisor  (dvs_q),
        .rem_out  (step_rem),
        .quot_out (step_quot)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; M_en low holds the current state.
    always_comb begin
        state_d = state_q;
        if (M_en) begin
            case (state_q)
                ST_IDLE: if (E_div_start) state_d = ST_BUSY;
                ST_BUSY: if (cnt_q == LAST_STEP) state_d = ST_FIX;
                ST_FIX:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy follows state, done is registered for exactly one enabled cycle.
    always_comb begin
        busy   = (state_q == ST_BUSY) || (state_q == ST_FIX);
        done_d = done_q;
        if (M_en) begin
            done_d = (state_q == ST_FIX);
        end
    end

    // Datapath next-state: operand capture, iteration and result fix-up.
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        div_zero_d = div_zero_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        if (start_acc) begin
            dvd_d      = E_src1;
            quot_d     = src1_mag;
            dvs_d      = src2_mag;
            rem_d      = '0;
            cnt_d      = '0;
            div_zero_d = (E_src2 == '0);
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
            neg_quot_d = src1_neg ^ src2_neg;
            neg_rem_d  = src1_neg;
`endif
        end else if (M_en && state_q == ST_BUSY) begin
            rem_d  = step_rem;
            quot_d = step_quot;
            cnt_d  = cnt_q + 1'b1;
        end else if (M_en && state_q == ST_FIX) begin
            if (div_zero_q) begin
                res_quot_d = '1;
                res_rem_d  = dvd_q;
            end else begin
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
                res_quot_d = neg_quot_q ? (WIDTH'(0) - quot_q) : quot_q;
                res_rem_d  = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
`else
                res_quot_d = quot_q;
                res_rem_d  = rem_q;
`endif
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            div_zero_q <= 1'b0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
            done_q     <= 1'b0;
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            div_zero_q <= div_zero_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
            done_q     <= done_d;
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign M_div_quot = res_quot_q;
    assign M_div_rem  = res_rem_q;
    assign M_div_busy = busy;
    assign M_div_done = done_q;

endmodule

// File: tb/tb_parallel_hypervisor_cpu_div_cell.sv
// Self-checking bench for parallel_hypervisor_cpu_div_cell (WIDTH = 32).
// Expected results come from a plain-arithmetic division model; the signed branch
// follows PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN exactly like the design build.
module tb_parallel_hypervisor_cpu_div_cell;

    logic        clk;
    logic        reset_n;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        start;
    logic        sgn;
    logic        en;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    parallel_hypervisor_cpu_div_cell #(
        .WIDTH (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .E_src1       (src1),
        .E_src2       (src2),
        .E_div_start  (start),
        .E_div_signed (sgn),
        .M_en         (en),
        .M_div_quot   (quot),
        .M_div_rem    (rem),
        .M_div_busy   (busy),
        .M_div_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: returns {quotient, remainder}.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        logic        use_s;
        int          sa;
        int          sb;
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
        use_s = s;
`else
        use_s = s & 1'b0;
`endif
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (use_s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Starts one operation at the current time (away from an edge) and waits for done.
    // lat is the number of edges after the start-sampling edge, -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [31:0] q, output logic [31:0] r,
                          output logic busy_ok);
        src1    = a;
        src2    = b;
        sgn     = s;
        en      = 1'b1;
        start   = 1'b1;
        lat     = -1;
        busy_ok = 1'b1;
        q       = 32'hx;
        r       = 32'hx;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                q   = quot;
                r   = rem;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b1;
        start   = 1'b1;
        sgn     = 1'b0;
        src1    = $urandom;
        src2    = $urandom;
        #1;
        n_checks++;
        if ({quot, rem, busy, done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b, expected all zero",
                     quot, rem, busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: got busy=%b done=%b, expected 0 0", busy, done);
        end
        @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({quot, rem, busy, done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got q=%h r=%h busy=%b done=%b, expected all zero",
                     quot, rem, busy, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [0:8];
        logic [31:0] vb [0:8];
        logic        vs [0:8];
        logic [63:0] exp_v;
        logic [31:0] q;
        logic [31:0] r;
        logic        bok;
        int          lat;
        va = '{32'd100, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFF9, 32'h8000_0000,
               32'd9, 32'd0, 32'hFFFF_FFFF, 32'd5};
        vb = '{32'd7, 32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF,
               32'd4, 32'd5, 32'd1, 32'hFFFF_FFFF};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            exp_v = ref_div(va[i], vb[i], vs[i]);
            run_op(va[i], vb[i], vs[i], lat, q, r, bok);
            n_checks++;
            if (lat != 33 || !bok) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles busy_ok=%b, expected 33 busy_ok=1",
                         i, lat, bok);
            end
            n_checks++;
            if ({q, r} !== exp_v) begin
                n_fail++;
                $display("FAIL directed_result[%0d] %h/%h s=%b: got q=%h r=%h, expected q=%h r=%h",
                         i, va[i], vb[i], vs[i], q, r, exp_v[63:32], exp_v[31:0]);
            end
            if (i == 3) begin
                n_checks++;
`ifdef PARALLEL_HYPERVISOR_CPU_DIV_SIGNED_EN
                if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
                    n_fail++;
                    $display("FAIL signed_m7_div_2: got q=%h r=%h, expected q=fffffffd r=ffffffff", q, r);
                end
`else
                if ({q, r} !== {32'h7FFF_FFFC, 32'd1}) begin
                    n_fail++;
                    $display("FAIL unsigned_m7_div_2: got q=%h r=%h, expected q=7ffffffc r=00000001", q, r);
                end
`endif
            end
        end
        // Last op was 5/-1; done must drop after one cycle and results must hold.
        exp_v = ref_div(32'd5, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_single_pulse: got busy=%b done=%b, expected 0 0", busy, done);
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if ({quot, rem} !== exp_v) begin
            n_fail++;
            $display("FAIL result_hold: got q=%h r=%h, expected q=%h r=%h",
                     quot, rem, exp_v[63:32], exp_v[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp_v;
        logic [31:0] q;
        logic [31:0] r;
        logic        bok;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            s     = 1'($urandom_range(0, 1));
            exp_v = ref_div(a, b, s);
            run_op(a, b, s, lat, q, r, bok);
            n_checks++;
            if (lat != 33 || {q, r} !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] %h/%h s=%b: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=33",
                         i, a, b, s, q, r, lat, exp_v[63:32], exp_v[31:0]);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        @(negedge clk);
        src1  = 32'd100;
        src2  = 32'd7;
        sgn   = 1'b0;
        en    = 1'b1;
        start = 1'b1;
        lat   = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            en    = (n >= 10 && n <= 14) ? 1'b0 : 1'b1;
            start = (n == 5 || n == 12 || n == 30);
            if (start) begin
                src1 = $urandom;
                src2 = $urandom_range(1, 1000);
            end
            @(posedge clk);
            #1;
            if (n == 12) begin
                n_checks++;
                if ({busy, done} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL stall_frozen_busy: got busy=%b done=%b, expected 1 0", busy, done);
                end
            end
            if (done === 1'b1) lat = n;
        end
        start = 1'b0;
        n_checks++;
        if (lat != 38 || quot !== 32'd14 || rem !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_result: got lat=%0d q=%0d r=%0d, expected lat=38 q=14 r=2", lat, quot, rem);
        end
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || quot !== 32'd14) begin
            n_fail++;
            $display("FAIL stall_done_freeze: got done=%b q=%0d, expected done=1 q=14", done, quot);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_done_release: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        logic [31:0] r;
        logic        bok;
        logic        spurious;
        int          lat;
        @(negedge clk);
        src1  = 32'd1000;
        src2  = 32'd3;
        sgn   = 1'b0;
        en    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({quot, rem, busy, done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got q=%h r=%h busy=%b done=%b, expected all zero",
                     quot, rem, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        spurious = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        n_checks++;
        if (spurious || quot !== 32'd0 || rem !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got spurious=%b q=%h r=%h, expected 0 0 0", spurious, quot, rem);
        end
        run_op(32'd1000, 32'd3, 1'b0, lat, q, r, bok);
        n_checks++;
        if (lat != 33 || q !== 32'd333 || r !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: got lat=%0d q=%0d r=%0d, expected lat=33 q=333 r=1", lat, q, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        logic [31:0] r;
        logic        bok;
        int          lat;
        @(negedge clk);
        run_op(32'd100, 32'd7, 1'b0, lat, q, r, bok);
        n_checks++;
        if (lat != 33 || q !== 32'd14 || r !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, expected lat=33 q=14 r=2", lat, q, r);
        end
        // run_op returns inside the done cycle, so this start is sampled while done is high.
        run_op(32'd9, 32'd4, 1'b0, lat, q, r, bok);
        n_checks++;
        if (lat != 33 || q !== 32'd2 || r !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d, expected lat=33 q=2 r=1", lat, q, r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
